// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path types: the {instruction, compressed, PC} entry handed from IF to decode,
// plus the canonical NOP and pointer sizing helper used by the fetch queue.
package fetch_queue_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef logic [INST_W-1:0] Inst;
    typedef logic [ADDR_W-1:0] InstAddr;

    typedef struct packed {
        Inst     inst;
        logic    compressed;
        InstAddr pc;
    } FetchEntry;

    // addi x0, x0, 0
    localparam Inst NOP_INST = 32'h00000013;

    // Index bits plus one wrap bit, so full and empty are distinguishable.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// IF-to-decode handshake bundle for the fetch queue; slave is the queue, master drives it.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);

    localparam int unsigned CW = ptr_width(DEPTH);

    logic                  i_flush;
    logic                  i_valid;
    logic [INST_WIDTH-1:0] i_inst;
    logic                  i_instCompressed;
    logic [ADDR_WIDTH-1:0] i_pc;
    logic                  o_ready;
    logic                  o_valid;
    logic [INST_WIDTH-1:0] o_inst;
    logic                  o_instCompressed;
    logic [ADDR_WIDTH-1:0] o_pc;
    logic                  i_ready;
    logic [CW-1:0]         o_count;

    modport slave (
        input  i_flush,
        input  i_valid,
        input  i_inst,
        input  i_instCompressed,
        input  i_pc,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_inst,
        output o_instCompressed,
        output o_pc,
        output o_count
    );

    modport master (
        output i_flush,
        output i_valid,
        output i_inst,
        output i_instCompressed,
        output i_pc,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_inst,
        input  o_instCompressed,
        input  o_pc,
        input  o_count
    );

endinterface

// File: rtl/fetch_queue_ptr.sv
// Read/write pointer pair with wrap bit for the fetch queue; derives full, empty and occupancy.
module fetch_queue_ptr
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    output logic [$clog2(DEPTH)-1:0]    wr_idx_o,
    output logic [$clog2(DEPTH)-1:0]    rd_idx_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [ptr_width(DEPTH)-1:0] count_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    // Defensive gating: an over-push or under-pop must never corrupt the pointers.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (rst_i || flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
    end

    assign wr_idx_o = wr_ptr_q[IW-1:0];
    assign rd_idx_o = rd_ptr_q[IW-1:0];
    assign count_o  = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between instruction fetch and decode. Registered storage, no input-to-output
// bypass; a flush from a redirect empties it in one cycle.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic          i_clock,
    input  logic          i_reset,
    fetch_queue_if.slave  bus
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
        $error("fetch_queue: DEPTH must be a power of two and at least 2");
    end

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic                  compressed;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        wr_entry;
    entry_t        head_entry;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          full;
    logic          empty;
    logic [PW-1:0] count;
    logic          push;
    logic          pop;
    logic          wr_en;

    // Refuse pushes when full even if the head pops this cycle; keeps ready off the pop path.
    assign bus.o_ready = !full && !i_reset;
    assign bus.o_valid = !empty;

    assign push  = bus.i_valid && bus.o_ready;
    assign pop   = bus.o_valid && bus.i_ready;
    assign wr_en = push && !bus.i_flush;

    fetch_queue_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk_i    (i_clock),
        .rst_i    (i_reset),
        .flush_i  (bus.i_flush),
        .push_i   (push),
        .pop_i    (pop),
        .wr_idx_o (wr_idx),
        .rd_idx_o (rd_idx),
        .full_o   (full),
        .empty_o  (empty),
        .count_o  (count)
    );

    assign wr_entry.inst       = bus.i_inst;
    assign wr_entry.compressed = bus.i_instCompressed;
    assign wr_entry.pc         = bus.i_pc;

    // Contents are not reset; the pointers alone decide what is live.
    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_entry;
        end
    end

    always_comb begin
        head_entry.inst       = INST_WIDTH'(NOP_INST);
        head_entry.compressed = 1'b0;
        head_entry.pc         = '0;
        if (!empty) begin
            head_entry = mem_q[rd_idx];
        end
    end

    assign bus.o_inst           = head_entry.inst;
    assign bus.o_instCompressed = head_entry.compressed;
    assign bus.o_pc             = head_entry.pc;
    assign bus.o_count          = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios then random traffic, all compared
// against a queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic i_clock = 1'b0;
    logic i_reset;

    fetch_queue_if #(.DEPTH(DEPTH), .INST_WIDTH(32), .ADDR_WIDTH(32)) fq_if ();

    fetch_queue #(
        .DEPTH      (DEPTH),
        .INST_WIDTH (32),
        .ADDR_WIDTH (32)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (fq_if)
    );

    always #5 i_clock = ~i_clock;

    int        n_checks = 0;
    int        n_fail   = 0;
    FetchEntry model_q[$];
    bit        cur_rst;

    task automatic check_equal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        FetchEntry head;
        int unsigned sz;
        sz = model_q.size();
        if (sz == 0) begin
            head = '{inst: NOP_INST, compressed: 1'b0, pc: '0};
        end else begin
            head = model_q[0];
        end
        check_equal({tag, ".valid"}, 64'(fq_if.o_valid), 64'(sz != 0));
        check_equal({tag, ".count"}, 64'(fq_if.o_count), 64'(sz));
        check_equal({tag, ".ready"}, 64'(fq_if.o_ready), 64'((sz < DEPTH) && !cur_rst));
        check_equal({tag, ".inst"}, 64'(fq_if.o_inst), 64'(head.inst));
        check_equal({tag, ".comp"}, 64'(fq_if.o_instCompressed), 64'(head.compressed));
        check_equal({tag, ".pc"}, 64'(fq_if.o_pc), 64'(head.pc));
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input string tag, input bit rst, input bit flush, input bit valid,
                        input FetchEntry e, input bit rdy);
        int unsigned sz;
        bit          do_pop;
        bit          do_push;
        i_reset                = rst;
        fq_if.i_flush          = flush;
        fq_if.i_valid          = valid;
        fq_if.i_inst           = e.inst;
        fq_if.i_instCompressed = e.compressed;
        fq_if.i_pc             = e.pc;
        fq_if.i_ready          = rdy;
        sz = model_q.size();
        if (rst || flush) begin
            model_q.delete();
        end else begin
            do_pop  = (sz != 0) && rdy;
            do_push = valid && (sz < DEPTH);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(e);
        end
        cur_rst = rst;
        @(posedge i_clock);
        @(negedge i_clock);
        check_outputs(tag);
    endtask

    function automatic FetchEntry mk(input logic [31:0] inst, input bit comp, input logic [31:0] pc);
        return '{inst: inst, compressed: comp, pc: pc};
    endfunction

    initial begin
        FetchEntry   e0;
        logic [31:0] pc;
        bit          comp;
        e0 = mk(32'h0, 1'b0, 32'h0);

        // Reset held two cycles, then idle.
        step("reset0", 1, 0, 0, e0, 0);
        step("reset1", 1, 0, 1, mk(32'hdeadbeef, 1, 32'h40), 1);
        step("idle", 0, 0, 0, e0, 0);

        // Single push then pop.
        step("push1", 0, 0, 1, mk(32'h00500093, 0, 32'h100), 0);
        step("pop1", 0, 0, 0, e0, 1);

        // Fill to DEPTH under back-pressure; a fifth push must be refused.
        for (int i = 0; i < 4; i++) begin
            step("fill", 0, 0, 1, mk(32'h1000 + 32'(i), i[0], 32'(i * 4)), 0);
        end
        step("fill_refuse", 0, 0, 1, mk(32'hbad, 1, 32'h10), 0);
        // Full with a pop in the same cycle: push still refused.
        step("full_pop_push", 0, 0, 1, mk(32'hbad1, 1, 32'h14), 1);
        for (int i = 0; i < 3; i++) begin
            step("drain", 0, 0, 0, e0, 1);
        end

        // Streaming with ready held high; occupancy never exceeds one.
        pc = 32'h2000;
        comp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step("wrap", 0, 0, 1, mk(32'h3000 + 32'(i), comp, pc), 1);
            check_equal("wrap_count_le1", 64'(fq_if.o_count <= 1), 64'd1);
            pc = pc + (comp ? 32'd2 : 32'd4);
            comp = ~comp;
        end
        step("wrap_drain", 0, 0, 0, e0, 1);

        // Simultaneous push/pop at count 2.
        step("sim_a", 0, 0, 1, mk(32'h4000, 0, 32'h400), 0);
        step("sim_b", 0, 0, 1, mk(32'h4001, 1, 32'h404), 0);
        step("sim_pp", 0, 0, 1, mk(32'h4002, 0, 32'h406), 1);
        check_equal("sim_pp_count", 64'(fq_if.o_count), 64'd2);

        // Flush with a concurrent push: everything discarded.
        step("fl_a", 0, 0, 1, mk(32'h5000, 0, 32'h500), 0);
        step("flush", 0, 1, 1, mk(32'h5fff, 1, 32'h5ff), 1);
        check_equal("flush_valid", 64'(fq_if.o_valid), 64'd0);
        step("post_flush", 0, 0, 1, mk(32'h6000, 1, 32'h600), 0);
        check_equal("post_flush_pc", 64'(fq_if.o_pc), 64'h600);

        // Reset mid-stream.
        step("rst_mid", 1, 0, 1, mk(32'h7000, 0, 32'h700), 0);
        step("rst_rel", 0, 0, 0, e0, 0);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            bit rst_r;
            bit fl_r;
            bit v_r;
            bit rdy_r;
            rst_r = ($urandom % 80) == 0;
            fl_r  = ($urandom % 25) == 0;
            v_r   = ($urandom % 4) != 0;
            rdy_r = (i % 100 < 50) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
            step("rand", rst_r, fl_r, v_r,
                 mk($urandom, 1'($urandom % 2), $urandom), rdy_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling FIFO directly downstream of the instruction-fetch stage, upstream of decode.
- Buffers fetched {instruction, compressed flag, PC} triples so that decode stalls do not force IF to refetch.
- Decode flushes on branch/jump redirect empty it in one cycle.
- Valid/ready handshake on both sides; registered storage; no combinational input-to-output path.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- INST_WIDTH, 32, instruction width (matches Inst).
- ADDR_WIDTH, 32, PC width (matches InstAddr).

Ports:
- i_clock  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_flush  in  1  discard all entries (redirect from EX/MEM).
- i_valid  in  1  IF presents an entry.
- i_inst  in  INST_WIDTH  expanded instruction from IF.
- i_instCompressed  in  1  original instruction was 16-bit.
- i_pc  in  ADDR_WIDTH  PC of the instruction.
- o_ready  out  1  queue can accept this cycle.
- o_valid  out  1  head entry available to decode.
- o_inst  out  INST_WIDTH  head instruction.
- o_instCompressed  out  1  head compressed flag.
- o_pc  out  ADDR_WIDTH  head PC.
- i_ready  in  1  decode accepts head this cycle.
- o_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Clock/reset: one clock, i_clock; reset i_reset is synchronous and active-high.
- Handshake:
  - push = i_valid & o_ready.
  - pop = o_valid & i_ready.
- Storage: DEPTH-entry register array.
  - Write pointer and read pointer are each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
  - Pointers wrap modulo 2*DEPTH naturally.
- Ready/valid:
  - o_ready = !full & !i_reset. There is no pass-through when full; a push is refused even if a pop occurs in the same cycle.
  - o_valid = !empty.
- Latency: an entry pushed at edge N is visible on o_* with o_valid=1 after edge N, i.e. in cycle N+1. No same-cycle bypass.
- Head outputs read combinationally from the array at the read index.
  - When empty: o_inst=32'h00000013 (NOP), o_instCompressed=0, o_pc=0.
- o_count = write pointer minus read pointer (modulo), range 0..DEPTH.
- Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- Simultaneous push and pop when empty: push only, since o_valid=0. Count becomes 1.
- Flush (i_flush=1): at the edge, both pointers set to 0 and count to 0.
  - Any push or pop in the same cycle is ignored.
  - o_valid=0 in the following cycle. o_ready stays 1.
- Reset (i_reset=1):
  - Pointers cleared to 0 at the edge; o_valid=0, o_count=0.
  - o_ready=0 while reset is asserted, 1 the cycle after release.
  - Reset has priority over flush.
  - Reset mid-stream discards all content; array contents need not be cleared.
- i_* sampled only when push=1; o_* are stable while o_valid=1 and i_ready=0.
- No X on outputs after the first reset edge.

Decomposition:
- Shared Types package:
  - FetchEntry packed struct {Inst inst; logic compressed; InstAddr pc}.
  - Constant NOP_INST = 32'h00000013.
  - Both reused by the decode stage and pipeline registers.
- One sub-module, fetch_queue_ptr:
  - Pointer/occupancy counter, instantiated once and holding both pointers.
  - Inputs: push, pop, flush, reset.
  - Outputs: indices, full, empty, count.
- Storage array and output muxing stay in fetch_queue.

Test Plan:
- Reset then idle: assert i_reset 2 cycles -> o_valid=0, o_count=0, o_ready=0 during reset and 1 after, o_inst=0x00000013, o_pc=0.
- Single push/pop: push {0x00500093, 0, 0x100} with i_ready=0 -> next cycle o_valid=1, o_pc=0x100, o_count=1; raise i_ready -> next cycle o_valid=0, o_count=0.
- Fill and back-pressure, DEPTH=4: push PCs 0x0,0x4,0x8,0xC with i_ready=0 -> o_count=4, o_ready=0; a 5th i_valid is not accepted; pop order 0x0,0x4,0x8,0xC.
- Wrap-around: 10 pushes (alternating 2/4-byte PC steps, compressed flag toggling) with continuous i_ready=1 -> every entry emerges in order with the correct flag; o_count never exceeds 1; pointers wrap without loss.
- Simultaneous push/pop at count=2 -> o_count stays 2, head advances, tail gets the new entry.
- Flush mid-stream: 3 entries queued, i_flush=1 together with i_valid=1 -> next cycle o_count=0, o_valid=0, pushed entry discarded; a push one cycle later appears alone at the head.
